// File: rtl/neuron_pkg.sv
// Shared types and default sizing for the neuron sweep scheduler.
package neuron_pkg;

    localparam int unsigned NUM_NEURONS_DEF = 128;
    localparam int unsigned IDX_W_DEF       = 7;
    localparam int unsigned MAX_OUT_DEF     = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running tick generator: tick every tick_period+1 cycles.
module tick_gen (
    input  logic        rawclk,
    input  logic        reset_n,
    input  logic [31:0] tick_period,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] lim_q, lim;

    // The limit is sampled only at count 0 and held for the whole interval, so a
    // lowered period can never leave the counter stranded above its compare value.
    always_comb begin
        lim   = (cnt_q == 32'd0) ? tick_period : lim_q;
        tick  = (cnt_q == lim);
        cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
    end

    // Counter and held-limit registers.
    always_ff @(posedge rawclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
            lim_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim;
        end
    end

endmodule

// File: rtl/neuron_sched.sv
// Sweep scheduler: on each tick issues every neuron index once to a shared
// datapath, tracks outstanding results, writes results back and flags errors.
module neuron_sched
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF,
    parameter int unsigned MAX_OUT     = MAX_OUT_DEF
) (
    input  logic             rawclk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [31:0]      tick_period,
    input  logic             dp_stall,
    output logic             dp_issue,
    output logic [IDX_W-1:0] dp_idx,
    input  logic             dp_ret_valid,
    input  logic [IDX_W-1:0] dp_ret_idx,
    output logic             wb_en,
    output logic [IDX_W-1:0] wb_idx,
    output logic             sweep_start,
    output logic             sweep_done,
    output logic             busy,
    input  logic             clear_err,
    output logic             overrun,
    output logic             seq_err,
    output logic [31:0]      sweep_cnt
);

    localparam int unsigned OutW = $clog2(MAX_OUT + 1);
    localparam int unsigned RetW = $clog2(NUM_NEURONS + 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NEURONS - 1);
    localparam logic [OutW-1:0]  MaxOutV = OutW'(MAX_OUT);
    localparam logic [RetW-1:0]  NumV    = RetW'(NUM_NEURONS);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] exp_q, exp_d;
    logic [OutW-1:0]  out_q, out_d;
    logic [RetW-1:0]  ret_q, ret_d;
    logic             overrun_q, overrun_d;
    logic             seq_err_q, seq_err_d;
    logic [31:0]      sweep_cnt_q, sweep_cnt_d;
    logic             wb_en_q;
    logic [IDX_W-1:0] wb_idx_q;

    logic tick;
    logic issue, start, done;
    logic accept, seq_hit, over_hit;

    tick_gen u_tick_gen (
        .rawclk      (rawclk),
        .reset_n     (reset_n),
        .tick_period (tick_period),
        .tick        (tick)
    );

    // A return only counts when something is actually in flight.
    assign accept = dp_ret_valid && (out_q != '0);

    // Sweep FSM: next state and the strobes decoded from the current state.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick && run) begin
                    start   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                issue = !dp_stall && (out_q < MaxOutV);
                if (issue && (idx_q == LastIdx)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((ret_q + RetW'(accept)) == NumV) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Index, in-flight, return-order and error bookkeeping.
    always_comb begin
        idx_d = idx_q;
        if (issue) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        out_d = out_q + OutW'(issue) - OutW'(accept);
        ret_d = ret_q;
        exp_d = exp_q;
        if (start) begin
            ret_d = '0;
            exp_d = '0;
        end else if (accept) begin
            ret_d = ret_q + 1'b1;
            exp_d = exp_q + 1'b1;
        end
        seq_hit     = dp_ret_valid && (!accept || (dp_ret_idx != exp_q));
        over_hit    = tick && (state_q != StIdle);
        // A new error in the same cycle as clear_err keeps the flag set.
        overrun_d   = over_hit || (overrun_q && !clear_err);
        seq_err_d   = seq_hit || (seq_err_q && !clear_err);
        sweep_cnt_d = done ? sweep_cnt_q + 32'd1 : sweep_cnt_q;
    end

    // State registers.
    always_ff @(posedge rawclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            exp_q       <= '0;
            out_q       <= '0;
            ret_q       <= '0;
            overrun_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            sweep_cnt_q <= 32'd0;
            wb_en_q     <= 1'b0;
            wb_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            exp_q       <= exp_d;
            out_q       <= out_d;
            ret_q       <= ret_d;
            overrun_q   <= overrun_d;
            seq_err_q   <= seq_err_d;
            sweep_cnt_q <= sweep_cnt_d;
            wb_en_q     <= dp_ret_valid;
            wb_idx_q    <= dp_ret_idx;
        end
    end

    assign dp_issue    = issue;
    assign dp_idx      = idx_q;
    assign sweep_start = start;
    assign sweep_done  = done;
    assign busy        = (state_q != StIdle) || start;
    assign wb_en       = wb_en_q;
    assign wb_idx      = wb_idx_q;
    assign overrun     = overrun_q;
    assign seq_err     = seq_err_q;
    assign sweep_cnt   = sweep_cnt_q;

endmodule

// File: tb/tb_neuron_sched.sv
// Bench for neuron_sched with an 8-neuron configuration and a reactive datapath.
module tb_neuron_sched;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 3;
    localparam int unsigned MO = 4;

    logic          rawclk = 1'b0;
    logic          reset_n;
    logic          run;
    logic [31:0]   tick_period;
    logic          dp_stall;
    logic          dp_issue;
    logic [W-1:0]  dp_idx;
    logic          dp_ret_valid;
    logic [W-1:0]  dp_ret_idx;
    logic          wb_en;
    logic [W-1:0]  wb_idx;
    logic          sweep_start;
    logic          sweep_done;
    logic          busy;
    logic          clear_err;
    logic          overrun;
    logic          seq_err;
    logic [31:0]   sweep_cnt;

    neuron_sched #(
        .NUM_NEURONS (N),
        .IDX_W       (W),
        .MAX_OUT     (MO)
    ) dut (
        .rawclk       (rawclk),
        .reset_n      (reset_n),
        .run          (run),
        .tick_period  (tick_period),
        .dp_stall     (dp_stall),
        .dp_issue     (dp_issue),
        .dp_idx       (dp_idx),
        .dp_ret_valid (dp_ret_valid),
        .dp_ret_idx   (dp_ret_idx),
        .wb_en        (wb_en),
        .wb_idx       (wb_idx),
        .sweep_start  (sweep_start),
        .sweep_done   (sweep_done),
        .busy         (busy),
        .clear_err    (clear_err),
        .overrun      (overrun),
        .seq_err      (seq_err),
        .sweep_cnt    (sweep_cnt)
    );

    always #5 rawclk = ~rawclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- datapath responder and event monitor ----------------
    typedef struct {
        int due;
        int idx;
    } ret_t;

    ret_t pend[$];
    int   cyc = 0;
    int   lat = 3;
    bit   swap_mode = 1'b0;
    int   n_issue = 0;
    int   n_wb = 0;
    int   n_start = 0;
    int   n_done = 0;
    int   start_cyc = 0;
    int   issue_idx_log[$];
    int   issue_cyc_log[$];

    // Swap mode makes index 2 come back one cycle before index 1.
    function automatic int lat_for(input int idx);
        if (swap_mode && idx == 1) return lat + 1;
        if (swap_mode && idx == 2) return lat - 1;
        return lat;
    endfunction

    initial begin
        dp_ret_valid = 1'b0;
        dp_ret_idx   = '0;
        forever begin
            @(negedge rawclk);
            if (dp_issue === 1'b1) begin
                pend.push_back('{due: cyc + lat_for(int'(dp_idx)), idx: int'(dp_idx)});
                issue_idx_log.push_back(int'(dp_idx));
                issue_cyc_log.push_back(cyc);
                n_issue++;
            end
            if (wb_en === 1'b1) n_wb++;
            if (sweep_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
            end
            if (sweep_done === 1'b1) n_done++;
            @(posedge rawclk);
            cyc++;
            #1;
            begin
                int best;
                best = -1;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].due <= cyc && (best < 0 || pend[i].due < pend[best].due)) best = i;
                end
                if (best >= 0) begin
                    dp_ret_valid = 1'b1;
                    dp_ret_idx   = W'(pend[best].idx);
                    pend.delete(best);
                end else begin
                    dp_ret_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- behavioural model and per-cycle compare ----------------
    logic [31:0] m_phase, m_len, m_cnt;
    bit          m_in, m_done, m_ov, m_se, m_pv;
    int          m_issued, m_ret, m_out;
    logic [W-1:0] m_pi;

    always @(negedge rawclk) begin
        logic [31:0] len;
        bit tick, busy_now, start, can_issue, accept, se_hit, ov_hit, done_next;
        if (!reset_n) begin
            m_phase = 0; m_len = 0; m_cnt = 0;
            m_in = 0; m_done = 0; m_ov = 0; m_se = 0; m_pv = 0; m_pi = '0;
            m_issued = 0; m_ret = 0; m_out = 0;
            chk("rst_dp_issue", dp_issue, 0);
            chk("rst_dp_idx", dp_idx, 0);
            chk("rst_sweep_start", sweep_start, 0);
            chk("rst_sweep_done", sweep_done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_wb_en", wb_en, 0);
            chk("rst_wb_idx", wb_idx, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_seq_err", seq_err, 0);
            chk("rst_sweep_cnt", sweep_cnt, 0);
        end else begin
            // Interval length is fixed when an interval begins.
            len       = (m_phase == 0) ? tick_period : m_len;
            tick      = (m_phase == len);
            busy_now  = m_in || m_done;
            start     = !busy_now && tick && run;
            can_issue = m_in && m_issued < N && !dp_stall && m_out < MO;
            accept    = dp_ret_valid && m_out > 0;
            se_hit    = dp_ret_valid && (!accept || int'(dp_ret_idx) != m_ret % (1 << W));
            ov_hit    = tick && busy_now;

            chk("dp_issue", dp_issue, can_issue);
            chk("dp_idx", dp_idx, m_issued % (1 << W));
            chk("sweep_start", sweep_start, start);
            chk("sweep_done", sweep_done, m_done);
            chk("busy", busy, busy_now || start);
            chk("wb_en", wb_en, m_pv);
            chk("wb_idx", wb_idx, m_pi);
            chk("overrun", overrun, m_ov);
            chk("seq_err", seq_err, m_se);
            chk("sweep_cnt", sweep_cnt, m_cnt);

            m_phase   = tick ? 32'd0 : m_phase + 32'd1;
            m_len     = len;
            done_next = m_in && m_issued == N && (m_ret + int'(accept)) == N;
            m_out     = m_out + int'(can_issue) - int'(accept);
            m_ret     = m_ret + int'(accept);
            m_issued  = m_issued + int'(can_issue);
            m_ov      = ov_hit || (m_ov && !clear_err);
            m_se      = se_hit || (m_se && !clear_err);
            m_pv      = dp_ret_valid;
            m_pi      = dp_ret_idx;
            if (m_done) begin
                m_cnt  = m_cnt + 32'd1;
                m_done = 0;
            end
            if (done_next) begin
                m_done   = 1;
                m_in     = 0;
                m_issued = 0;
            end
            if (start) begin
                m_in     = 1;
                m_issued = 0;
                m_ret    = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr_mon();
        n_issue = 0;
        n_wb    = 0;
        n_start = 0;
        n_done  = 0;
        issue_idx_log.delete();
        issue_cyc_log.delete();
    endtask

    // sel: 0 = sweep starts, 1 = sweep dones, 2 = issues.
    task automatic wait_until(input int sel, input int target, input int budget,
                              input string name);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(posedge rawclk);
            n++;
            case (sel)
                0:       hit = (n_start >= target);
                1:       hit = (n_done >= target);
                default: hit = (n_issue >= target);
            endcase
        end
        chk(name, hit, 1);
    endtask

    task automatic pulse_clear();
        @(posedge rawclk);
        #1 clear_err = 1'b1;
        @(posedge rawclk);
        #1 clear_err = 1'b0;
    endtask

    task automatic chk_order(input string name);
        chk({name, "_count"}, n_issue, N);
        for (int i = 0; i < issue_idx_log.size() && i < N; i++) begin
            chk({name, "_idx"}, issue_idx_log[i], i);
        end
    endtask

    initial begin
        int rel_cyc;
        reset_n     = 1'b0;
        run         = 1'b0;
        dp_stall    = 1'b0;
        clear_err   = 1'b0;
        tick_period = 32'd9;
        repeat (3) @(posedge rawclk);
        #1;
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_idx", dp_idx, 0);
        chk("lit_reset_cnt", sweep_cnt, 0);

        // Basic sweep, period 9, latency 3; run dropped mid-sweep.
        reset_n = 1'b1;
        run     = 1'b1;
        rel_cyc = cyc;
        clr_mon();
        wait_until(0, 1, 30, "wait_start_a");
        #1 run = 1'b0;
        chk("lit_first_start_cycle", start_cyc - rel_cyc, 9);
        wait_until(1, 1, 40, "wait_done_a");
        repeat (3) @(posedge rawclk);
        #1;
        chk_order("a");
        chk("lit_a_wb", n_wb, 8);
        chk("lit_a_cnt", sweep_cnt, 1);
        chk("lit_a_overrun", overrun, 1);
        pulse_clear();
        repeat (20) @(posedge rawclk);
        #1;
        chk("lit_a_no_restart", n_start, 1);
        chk("lit_a_overrun_clr", overrun, 0);

        // Five-cycle stall after three issues.
        clr_mon();
        run = 1'b1;
        wait_until(0, 1, 30, "wait_start_b");
        #1 run = 1'b0;
        wait_until(2, 3, 20, "wait_issue_b");
        #1 dp_stall = 1'b1;
        repeat (5) @(posedge rawclk);
        #1 dp_stall = 1'b0;
        wait_until(1, 1, 40, "wait_done_b");
        repeat (3) @(posedge rawclk);
        #1;
        chk_order("b");
        if (issue_cyc_log.size() > 3) chk("lit_b_gap", issue_cyc_log[3] - issue_cyc_log[2], 6);
        chk("lit_b_cnt", sweep_cnt, 2);
        pulse_clear();

        // Long latency: in-flight limit.
        clr_mon();
        lat = 10;
        run = 1'b1;
        wait_until(0, 1, 30, "wait_start_c");
        #1 run = 1'b0;
        wait_until(1, 1, 80, "wait_done_c");
        repeat (3) @(posedge rawclk);
        #1;
        chk_order("c");
        if (issue_cyc_log.size() > 4) chk("lit_c_resume", issue_cyc_log[4] - issue_cyc_log[0], 11);
        chk("lit_c_cnt", sweep_cnt, 3);
        lat = 3;
        pulse_clear();

        // Short period: ticks arrive while busy.
        clr_mon();
        tick_period = 32'd3;
        run = 1'b1;
        wait_until(0, 1, 30, "wait_start_d");
        #1 run = 1'b0;
        repeat (5) @(posedge rawclk);
        #1;
        chk("lit_d_overrun", overrun, 1);
        pulse_clear();
        wait_until(1, 1, 40, "wait_done_d");
        tick_period = 32'd9;
        repeat (3) @(posedge rawclk);
        #1;
        chk_order("d");
        chk("lit_d_cnt", sweep_cnt, 4);
        pulse_clear();
        repeat (2) @(posedge rawclk);
        #1 chk("lit_d_overrun_clr", overrun, 0);

        // Out-of-order return of indices 1 and 2.
        clr_mon();
        swap_mode = 1'b1;
        run = 1'b1;
        wait_until(0, 1, 30, "wait_start_e");
        #1 run = 1'b0;
        wait_until(1, 1, 40, "wait_done_e");
        repeat (3) @(posedge rawclk);
        #1;
        chk("lit_e_seq_err", seq_err, 1);
        chk("lit_e_wb", n_wb, 8);
        chk("lit_e_done", n_done, 1);
        chk("lit_e_cnt", sweep_cnt, 5);
        swap_mode = 1'b0;
        pulse_clear();
        #2 chk("lit_e_seq_err_clr", seq_err, 0);

        // Asynchronous reset during drain, then a fresh sweep.
        clr_mon();
        run = 1'b1;
        wait_until(0, 1, 30, "wait_start_f");
        #1 run = 1'b0;
        wait_until(2, 8, 30, "wait_issue_f");
        #3 reset_n = 1'b0;
        #1;
        chk("lit_f_busy", busy, 0);
        chk("lit_f_idx", dp_idx, 0);
        chk("lit_f_cnt", sweep_cnt, 0);
        chk("lit_f_overrun", overrun, 0);
        chk("lit_f_issue", dp_issue, 0);
        @(posedge rawclk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge rawclk);
        #1 chk("lit_f_late_seq_err", seq_err, 1);
        pulse_clear();
        clr_mon();
        run = 1'b1;
        wait_until(0, 1, 30, "wait_start_g");
        #1 run = 1'b0;
        wait_until(1, 1, 40, "wait_done_g");
        repeat (3) @(posedge rawclk);
        #1;
        chk_order("g");
        chk("lit_g_cnt", sweep_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
